// File: rtl/tl_sensor_cond.sv
// tl_sensor_cond: vehicle sensor conditioning (sync, debounce, car count, optional stuck detect via TL_SNS_STUCK_DET_EN)
module tl_sns_chan #(
  parameter int DB_CYCLES    = 4,
  parameter int DEPART_CYCLES = 8,
  parameter int CNT_W        = 4,
  parameter int STUCK_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic green,
  output logic t,
  output logic fault
);
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int DPW = $clog2(DEPART_CYCLES + 1);
  logic s1, sync, db, db_q, run, arr, dep;
  logic [DBW-1:0] db_cnt;
  logic [DPW-1:0] tmr;
  logic [CNT_W-1:0] cnt;
  assign run = green && cnt != '0;
  assign arr = db && !db_q;
  assign dep = run && tmr == DPW'(DEPART_CYCLES - 1);
  assign t = cnt != '0 || (db && !fault);
  // Two-flop synchronizer feeding a consecutive-mismatch debouncer
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= 1'b0;
      sync <= 1'b0;
      db <= 1'b0;
      db_q <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= raw;
      sync <= s1;
      db_q <= db;
      if (sync == db) db_cnt <= '0;
      else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
        db <= sync;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  // Timer runs only while green with cars waiting; each rollover is one departure
  always_ff @(posedge clk or posedge reset)
    if (reset) tmr <= '0;
    else tmr <= run && !dep ? tmr + 1'b1 : '0;
  // Waiting-car count saturates at both ends; coincident arrival and departure cancel
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (arr && !dep && cnt != '1) cnt <= cnt + 1'b1;
    else if (dep && !arr) cnt <= cnt - 1'b1;
`ifdef TL_SNS_STUCK_DET_EN
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  logic [SW-1:0] stk;
  // Count consecutive debounced-high cycles; the fault latches until reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stk <= '0;
      fault <= 1'b0;
    end else begin
      stk <= db ? (stk == SW'(STUCK_CYCLES) ? stk : stk + 1'b1) : '0;
      if (db && stk == SW'(STUCK_CYCLES - 1)) fault <= 1'b1;
    end
`else
  assign fault = 1'b0;
`endif
endmodule

module tl_sensor_cond #(
  parameter int DB_CYCLES     = 4,
  parameter int DEPART_CYCLES = 8,
  parameter int CNT_W         = 4,
  parameter int STUCK_CYCLES  = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sens_a_raw,
  input  logic       sens_b_raw,
  input  logic [1:0] La,
  input  logic [1:0] Lb,
  output logic       Ta,
  output logic       Tb,
  output logic       fault_a,
  output logic       fault_b
);
  tl_sns_chan #(.DB_CYCLES(DB_CYCLES), .DEPART_CYCLES(DEPART_CYCLES), .CNT_W(CNT_W), .STUCK_CYCLES(STUCK_CYCLES)) u_a (
    .clk(clk), .reset(reset), .raw(sens_a_raw), .green(La == 2'b00), .t(Ta), .fault(fault_a)
  );
  tl_sns_chan #(.DB_CYCLES(DB_CYCLES), .DEPART_CYCLES(DEPART_CYCLES), .CNT_W(CNT_W), .STUCK_CYCLES(STUCK_CYCLES)) u_b (
    .clk(clk), .reset(reset), .raw(sens_b_raw), .green(Lb == 2'b00), .t(Tb), .fault(fault_b)
  );
endmodule

// File: tb/tb_tl_sensor_cond.sv
// tb_tl_sensor_cond: randomized and directed checks of tl_sensor_cond against a behavioural model
module tb_tl_sensor_cond;
  localparam int DB = 4, DEP = 8, CW = 4, STK = 256;
  localparam logic [1:0] GREEN = 2'b00, RED = 2'b10;
  logic clk = 1'b0, reset = 1'b1, sa = 1'b0, sb = 1'b0;
  logic [1:0] la = RED, lb = RED;
  logic ta, tb, fa, fb;
  int vec = 0, err = 0;
  bit m_hist[2][$];
  bit m_db[2], m_arr[2], m_fault[2];
  int m_cars[2], m_gt[2], m_run[2];

  tl_sensor_cond #(.DB_CYCLES(DB), .DEPART_CYCLES(DEP), .CNT_W(CW), .STUCK_CYCLES(STK)) dut (
    .clk(clk), .reset(reset), .sens_a_raw(sa), .sens_b_raw(sb), .La(la), .Lb(lb),
    .Ta(ta), .Tb(tb), .fault_a(fa), .fault_b(fb)
  );

  always #5 clk = ~clk;

  function automatic void m_clear();
    for (int c = 0; c < 2; c++) begin
      m_hist[c].delete();
      for (int i = 0; i < DB + 2; i++) m_hist[c].push_back(1'b0);
      m_db[c] = 0; m_arr[c] = 0; m_fault[c] = 0;
      m_cars[c] = 0; m_gt[c] = 0; m_run[c] = 0;
    end
  endfunction

  // One rising edge of the model: the debounced level flips once the last DB
  // synchronized samples (raw delayed by two edges) all disagree with it.
  function automatic void m_edge();
    bit raw[2];
    bit g[2];
    bit dep, flip, old;
    int n;
    raw[0] = sa; raw[1] = sb;
    g[0] = (la == GREEN); g[1] = (lb == GREEN);
    for (int c = 0; c < 2; c++) begin
`ifdef TL_SNS_STUCK_DET_EN
      if (m_db[c]) begin
        m_run[c]++;
        if (m_run[c] >= STK) m_fault[c] = 1;
      end else m_run[c] = 0;
`endif
      dep = 0;
      if (g[c] && m_cars[c] > 0) begin
        m_gt[c]++;
        if (m_gt[c] == DEP) begin dep = 1; m_gt[c] = 0; end
      end else m_gt[c] = 0;
      m_cars[c] = m_cars[c] + int'(m_arr[c]) - int'(dep);
      if (m_cars[c] > 2**CW - 1) m_cars[c] = 2**CW - 1;
      m_hist[c].push_back(raw[c]);
      n = m_hist[c].size();
      flip = 1;
      for (int i = n - 2 - DB; i <= n - 3; i++) if (m_hist[c][i] == m_db[c]) flip = 0;
      old = m_db[c];
      if (flip) m_db[c] = !m_db[c];
      m_arr[c] = m_db[c] && !old;
      if (n > 64) void'(m_hist[c].pop_front());
    end
  endfunction

  function automatic logic exp_t(int c);
    return m_cars[c] != 0 || (m_db[c] && !m_fault[c]);
  endfunction

  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    m_clear();
    @(negedge clk);
    reset = 1'b0;
    m_clear();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vec++; if (ta !== 1'b0) begin err++; $display("FAIL reset_ta: got %b want 0", ta); end
    vec++; if (tb !== 1'b0) begin err++; $display("FAIL reset_tb: got %b want 0", tb); end
    vec++; if (fa !== 1'b0) begin err++; $display("FAIL reset_fault_a: got %b want 0", fa); end
    vec++; if (fb !== 1'b0) begin err++; $display("FAIL reset_fault_b: got %b want 0", fb); end
    vec++; if (dut.u_a.cnt !== 4'd0) begin err++; $display("FAIL reset_cnt_a: got %0d want 0", dut.u_a.cnt); end
    reset = 1'b0;
    m_clear();
    repeat (3) tick();
    vec++; if ({ta, tb} !== 2'b00) begin err++; $display("FAIL post_reset_t: got %b want 00", {ta, tb}); end
  endtask

  task automatic test_arrival();
    sa = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) begin
        vec++; if (dut.u_a.db !== 1'b0) begin err++; $display("FAIL arr_db_e5: got %b want 0", dut.u_a.db); end
        vec++; if (ta !== 1'b0) begin err++; $display("FAIL arr_ta_e5: got %b want 0", ta); end
      end
      if (e == 6) begin
        vec++; if (dut.u_a.db !== 1'b1) begin err++; $display("FAIL arr_db_e6: got %b want 1", dut.u_a.db); end
        vec++; if (ta !== 1'b1) begin err++; $display("FAIL arr_ta_e6: got %b want 1", ta); end
        vec++; if (dut.u_a.cnt !== 4'd0) begin err++; $display("FAIL arr_cnt_e6: got %0d want 0", dut.u_a.cnt); end
      end
      if (e == 7) begin
        vec++; if (dut.u_a.cnt !== 4'd1) begin err++; $display("FAIL arr_cnt_e7: got %0d want 1", dut.u_a.cnt); end
      end
    end
    sa = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    la = GREEN;
    repeat (3) tick();
    sa = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    m_clear();
    #1;
    vec++; if (dut.u_a.cnt !== 4'd0) begin err++; $display("FAIL mid_reset_cnt: got %0d want 0", dut.u_a.cnt); end
    vec++; if (ta !== 1'b0) begin err++; $display("FAIL mid_reset_ta: got %b want 0", ta); end
    vec++; if (dut.u_a.db_cnt !== '0) begin err++; $display("FAIL mid_reset_dbcnt: got %0d want 0", dut.u_a.db_cnt); end
    @(negedge clk);
    reset = 1'b0;
    m_clear();
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) begin
        vec++; if (dut.u_a.db !== 1'b0) begin err++; $display("FAIL restart_db_e5: got %b want 0", dut.u_a.db); end
      end
      if (e == 6) begin
        vec++; if (dut.u_a.db !== 1'b1) begin err++; $display("FAIL restart_db_e6: got %b want 1", dut.u_a.db); end
      end
    end
    sa = 1'b0;
    la = RED;
    repeat (8) tick();
  endtask

  task automatic test_glitch();
    apply_reset();
    sb = 1'b1;
    repeat (3) tick();
    sb = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      vec++; if (dut.u_b.db !== 1'b0) begin err++; $display("FAIL glitch_db_b: got %b want 0", dut.u_b.db); end
      vec++; if (dut.u_b.cnt !== 4'd0) begin err++; $display("FAIL glitch_cnt_b: got %0d want 0", dut.u_b.cnt); end
      vec++; if (tb !== 1'b0) begin err++; $display("FAIL glitch_tb: got %b want 0", tb); end
    end
  endtask

  task automatic test_depart();
    apply_reset();
    la = RED;
    repeat (3) begin
      sa = 1'b1;
      repeat (6) tick();
      sa = 1'b0;
      repeat (7) tick();
    end
    vec++; if (dut.u_a.cnt !== 4'd3) begin err++; $display("FAIL dep_cnt_start: got %0d want 3", dut.u_a.cnt); end
    la = GREEN;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i % 8 == 0) begin
        vec++; if (dut.u_a.cnt !== 4'(3 - i / 8)) begin err++; $display("FAIL dep_cnt_%0d: got %0d want %0d", i, dut.u_a.cnt, 3 - i / 8); end
      end
      if (i == 23) begin
        vec++; if (ta !== 1'b1) begin err++; $display("FAIL dep_ta_23: got %b want 1", ta); end
      end
      if (i == 24) begin
        vec++; if (ta !== 1'b0) begin err++; $display("FAIL dep_ta_24: got %b want 0", ta); end
      end
    end
    la = RED;
  endtask

  task automatic test_saturate();
    apply_reset();
    la = RED;
    for (int k = 1; k <= 20; k++) begin
      sa = 1'b1;
      repeat (6) tick();
      sa = 1'b0;
      tick();
      vec++; if (dut.u_a.cnt !== 4'(k < 15 ? k : 15)) begin err++; $display("FAIL sat_cnt_%0d: got %0d want %0d", k, dut.u_a.cnt, k < 15 ? k : 15); end
      repeat (6) tick();
    end
    vec++; if (ta !== 1'b1) begin err++; $display("FAIL sat_ta: got %b want 1", ta); end
  endtask

  task automatic test_align();
    apply_reset();
    la = RED;
    repeat (2) begin
      sa = 1'b1;
      repeat (6) tick();
      sa = 1'b0;
      repeat (7) tick();
    end
    la = GREEN;
    tick();
    sa = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (e <= 7) begin
        vec++; if (dut.u_a.cnt !== 4'd2) begin err++; $display("FAIL align_cnt_e%0d: got %0d want 2", e, dut.u_a.cnt); end
      end
      if (e == 15) begin
        vec++; if (dut.u_a.cnt !== 4'd1) begin err++; $display("FAIL align_cnt_e15: got %0d want 1", dut.u_a.cnt); end
      end
    end
    sa = 1'b0;
    la = RED;
    repeat (8) tick();
  endtask

  task automatic test_stuck();
    apply_reset();
`ifdef TL_SNS_STUCK_DET_EN
    la = GREEN;
    sa = 1'b1;
    for (int e = 1; e <= 300; e++) begin
      tick();
      if (e == 200) begin
        vec++; if ({ta, fa} !== 2'b10) begin err++; $display("FAIL stuck_e200 ta,fault: got %b want 10", {ta, fa}); end
      end
      if (e == 261) begin
        vec++; if (fa !== 1'b0) begin err++; $display("FAIL stuck_e261: got %b want 0", fa); end
      end
      if (e == 262) begin
        vec++; if ({ta, fa} !== 2'b01) begin err++; $display("FAIL stuck_e262 ta,fault: got %b want 01", {ta, fa}); end
      end
    end
    sa = 1'b0;
    repeat (10) tick();
    vec++; if (fa !== 1'b1) begin err++; $display("FAIL stuck_sticky: got %b want 1", fa); end
    apply_reset();
    vec++; if (fa !== 1'b0) begin err++; $display("FAIL stuck_cleared: got %b want 0", fa); end
`else
    la = RED;
    sa = 1'b1;
    for (int e = 1; e <= 300; e++) begin
      tick();
      if (e % 50 == 0) begin
        vec++; if ({fa, fb} !== 2'b00) begin err++; $display("FAIL nofault_e%0d: got %b want 00", e, {fa, fb}); end
      end
    end
    vec++; if (ta !== 1'b1) begin err++; $display("FAIL nofault_ta: got %b want 1", ta); end
    sa = 1'b0;
    repeat (8) tick();
`endif
    la = RED;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 4) == 0) sa = !sa;
      if ($urandom_range(0, 4) == 0) sb = !sb;
      if ($urandom_range(0, 15) == 0) la = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) lb = 2'($urandom_range(0, 3));
      tick();
      vec++; if (ta !== exp_t(0)) begin err++; $display("FAIL rnd_ta @%0d: got %b want %b", i, ta, exp_t(0)); end
      vec++; if (tb !== exp_t(1)) begin err++; $display("FAIL rnd_tb @%0d: got %b want %b", i, tb, exp_t(1)); end
      vec++; if (dut.u_a.cnt !== 4'(m_cars[0])) begin err++; $display("FAIL rnd_cnt_a @%0d: got %0d want %0d", i, dut.u_a.cnt, m_cars[0]); end
      vec++; if (dut.u_b.cnt !== 4'(m_cars[1])) begin err++; $display("FAIL rnd_cnt_b @%0d: got %0d want %0d", i, dut.u_b.cnt, m_cars[1]); end
      vec++; if ({fa, fb} !== {m_fault[0], m_fault[1]}) begin err++; $display("FAIL rnd_fault @%0d: got %b want %b", i, {fa, fb}, {m_fault[0], m_fault[1]}); end
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_arrival();
    test_reset_mid();
    test_glitch();
    test_depart();
    test_saturate();
    test_align();
    test_stuck();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
